onchip_rom_stream_reader: RTL and testbench
===========================================

# onchip_rom_stream_reader

Avalon-MM read master that fetches a contiguous block of 32-bit words from the single-port on-chip memory slave and re-emits the words as an Avalon-ST packet. It sits between the on-chip memory's s1 port and any streaming consumer, such as a DSP filter or a FIFO toward the Nios II side. Reads are issued against the memory's fixed read latency of one cycle. A small internal FIFO absorbs sink backpressure.

## Interface
Parameters:
- ADDR_W, 14: word address width of the memory slave.
- DATA_W, 32: data width.
- MEM_WORDS, 10240: number of valid words in the memory. Requests beyond this are rejected.
- FIFO_DEPTH, 4: output FIFO depth. Must be a power of two and at least 2. A depth of 3 or more sustains 1 word/cycle.

Ports:
- clk  in  1  system clock. The only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command strobe. Sampled only in IDLE.
- start_addr  in  ADDR_W  first word address.
- word_count  in  ADDR_W+1  number of words to transfer, 0..MEM_WORDS.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- error  out  1  one-cycle pulse when a start is rejected.
- avm_address  out  ADDR_W  read address.
- avm_chipselect  out  1  read strobe. The slave has no waitrequest.
- avm_write  out  1  tied 0.
- avm_byteenable  out  4  tied 4'hF.
- avm_clken  out  1  tied 1.
- avm_readdata  in  DATA_W  valid exactly 1 cycle after a cycle with chipselect=1.
- st_data  out  DATA_W  stream data.
- st_valid  out  1  stream valid.
- st_ready  in  1  sink ready. Ready latency is 0.
- st_sop  out  1  asserted with the first word of the packet.
- st_eop  out  1  asserted with the last word of the packet.

## Operation
- States are IDLE, READ, DRAIN and FINISH.
- IDLE with start=1:
  - If word_count==0, or start_addr+word_count > MEM_WORDS (computed at ADDR_W+2 bits, no wrap), pulse error and stay in IDLE.
  - Otherwise latch the address pointer and both remaining counters, set busy, and go to READ.
- READ issues a read on any cycle where fifo_count + inflight < FIFO_DEPTH:
  - Drive chipselect=1 and avm_address=pointer.
  - Increment the pointer and decrement issue_remaining.
  - inflight is a 1-bit register set on issue; it means the next cycle's readdata is valid.
- Any cycle with inflight=1 writes avm_readdata into the FIFO. Space is guaranteed by the issue rule, so overflow is impossible.
- When issue_remaining reaches 0, go from READ to DRAIN. chipselect stays 0 from then on.
- DRAIN moves to FINISH when the last word (st_eop) is handshaken (st_valid & st_ready).
- FINISH pulses done for 1 cycle, clears busy and returns to IDLE.
- Stream words are numbered by an output counter:
  - st_sop=1 when the head-of-FIFO word is word 0.
  - st_eop=1 when it is word word_count-1.
  - Both are asserted on the same word when word_count==1.
- st_data, st_sop and st_eop hold stable while st_valid=1 and st_ready=0.
- start while busy is ignored: no error and no effect.
- Simultaneous FIFO write and read in one cycle: fifo_count is unchanged and the data stays in order.
- Reset mid-transfer returns everything to IDLE. The in-flight read is discarded, the FIFO is emptied, and no done or error is produced.

## Timing
- Reset values: busy=0, done=0, error=0, avm_chipselect=0, avm_address=0, st_valid=0, st_sop=0, st_eop=0, st_data=0.
- avm_address and avm_chipselect are registered outputs.
- Cycle numbering from an accepted start in cycle 0:
  - cycle 0: start accepted. busy=1 from cycle 1.
  - cycle 1: first chipselect.
  - cycle 2: readdata is valid and written into the FIFO.
  - cycle 3: st_valid=1 with st_sop.
- First-word latency is 3 cycles.
- Throughput with st_ready held at 1 and FIFO_DEPTH≥3 is one word per cycle. An N-word transfer puts st_eop in cycle N+2 and done in cycle N+3.
- error pulses in cycle 1 after a rejected start in cycle 0.

## Test plan
- **Basic read:** memory preloaded with word i = 32'hA5000000+i; start_addr=16, word_count=8, st_ready=1 -> the stream carries A5000010..A5000017 on consecutive cycles 3..10, sop on cycle 3, eop on cycle 10, done on cycle 11.
- **Backpressure:** same transfer with st_ready toggling 1010... -> same data in order; chipselect never issues while fifo_count+inflight=4; no word is lost or duplicated.
- **Boundary range:** start_addr=10236, word_count=4 -> words 10236..10239 are delivered. start_addr=10237, word_count=4 -> error pulses 1 cycle later, busy stays 0 and no chipselect occurs. word_count=0 -> error.
- **Single word:** word_count=1 -> one beat with sop=eop=1, followed by done.
- **Busy and reset:** start pulsed again mid-transfer -> ignored. Reset asserted after 3 words with st_ready=0 -> all outputs return to reset values at once. A new start afterwards delivers the full packet with fresh sop.

Source files
------------

// File: rtl/onchip_rom_stream_reader.sv
// Avalon-MM read master that streams a contiguous block of on-chip memory words
// out as a single Avalon-ST packet, with a small FIFO absorbing sink backpressure.
module onchip_rom_stream_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int MEM_WORDS  = 10240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic              avm_clken,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);

  localparam int WC_W  = ADDR_W + 1;
  localparam int EXT_W = ADDR_W + 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [EXT_W-1:0] MEM_LIMIT = EXT_W'(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ptr;
  logic [WC_W-1:0]   issue_rem;
  logic [WC_W-1:0]   out_rem;
  logic              sop_pend;
  logic              vld_p1;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept;
  logic              reject;
  logic              issue;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  cap;

  function automatic logic range_ok(input logic [ADDR_W-1:0] addr,
                                    input logic [WC_W-1:0]   cnt);
    logic [EXT_W-1:0] end_addr;
    end_addr = {2'b00, addr} + {1'b0, cnt};
    return (cnt != '0) && (end_addr <= MEM_LIMIT);
  endfunction

  assign avm_write      = 1'b0;
  assign avm_byteenable = 4'hF;
  assign avm_clken      = 1'b1;

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign st_valid = (fifo_count != '0);
  assign st_data  = st_valid ? fifo_mem[rd_ptr] : '0;
  assign st_sop   = st_valid & sop_pend;
  assign st_eop   = st_valid & (out_rem == WC_W'(1));
  assign pop      = st_valid & st_ready;

  // A request issued now lands in the FIFO two edges later; a pop this cycle frees a slot in time.
  assign occ = {1'b0, fifo_count} + OCC_W'(avm_chipselect) + OCC_W'(vld_p1);
  assign cap = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_ok(start_addr, word_count)) begin
            accept     = 1'b1;
            state_next = READ;
          end else begin
            reject = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_rem == '0) begin
          state_next = DRAIN;
        end else if (occ < cap) begin
          issue = 1'b1;
          if (issue_rem == WC_W'(1)) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && st_eop) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // p0: read request issue; the accepting cycle issues the first word itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error          <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_address    <= '0;
      ptr            <= '0;
      issue_rem      <= '0;
    end else begin
      error          <= reject;
      avm_chipselect <= accept | issue;
      if (accept) begin
        avm_address <= start_addr;
        ptr         <= start_addr + ADDR_W'(1);
        issue_rem   <= word_count - WC_W'(1);
      end else if (issue) begin
        avm_address <= ptr;
        ptr         <= ptr + ADDR_W'(1);
        issue_rem   <= issue_rem - WC_W'(1);
      end
    end
  end

  // p1: readdata valid one cycle after chipselect, written straight into the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      vld_p1 <= avm_chipselect;
      if (vld_p1) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({vld_p1, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr] <= avm_readdata;
  end

  // p2: packet framing counts handshaken beats at the FIFO head
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rem  <= '0;
      sop_pend <= 1'b0;
    end else if (accept) begin
      out_rem  <= word_count;
      sop_pend <= 1'b1;
    end else if (pop) begin
      out_rem  <= out_rem - WC_W'(1);
      sop_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onchip_rom_stream_reader.sv
// Randomized bench for onchip_rom_stream_reader: a ROM model answers reads and a
// packet-level reference (expected words = rom[start .. start+count-1]) checks the stream.
module tb_onchip_rom_stream_reader;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int MEM_WORDS  = 10240;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   word_count;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic              avm_clken;
  logic [DATA_W-1:0] avm_readdata;
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_sop;
  logic              st_eop;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] rom [MEM_WORDS];

  onchip_rom_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable), .avm_clken(avm_clken),
    .avm_readdata(avm_readdata), .st_data(st_data), .st_valid(st_valid),
    .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // On-chip memory: fixed one-cycle read latency, garbage when not selected.
  always @(posedge clk) begin
    if (avm_chipselect && int'(avm_address) < MEM_WORDS) avm_readdata <= rom[avm_address];
    else avm_readdata <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_cs"},    32'(avm_chipselect), 32'd0);
    chk({tag, "_addr"},  32'(avm_address), 32'd0);
    chk({tag, "_valid"}, 32'(st_valid), 32'd0);
    chk({tag, "_sop"},   32'(st_sop), 32'd0);
    chk({tag, "_eop"},   32'(st_eop), 32'd0);
    chk({tag, "_data"},  st_data, 32'd0);
    chk({tag, "_ties"},  {29'd0, avm_write, avm_clken, 1'b0} | 32'(avm_byteenable) << 4, 32'h0000_00F2);
  endtask

  // mode: 0 = ready always high, 1 = ready toggling, 2 = random ready.
  task automatic run_xfer(input int sa, input int wc, input int mode, input bit exact, input int poke_c);
    bit          rej;
    bit          finished;
    bit          saw_err;
    bit          hold_v;
    logic [31:0] hold_d;
    logic        hold_s;
    logic        hold_e;
    int          issued;
    int          popped;
    int          budget;
    rej      = (wc == 0) || (sa + wc > MEM_WORDS);
    issued   = 0;
    popped   = 0;
    finished = 1'b0;
    saw_err  = 1'b0;
    hold_v   = 1'b0;
    hold_d   = '0;
    hold_s   = 1'b0;
    hold_e   = 1'b0;
    budget   = 4 * wc + 40;
    start      = 1'b1;
    start_addr = ADDR_W'(sa);
    word_count = (ADDR_W+1)'(wc);
    st_ready   = (mode == 0);
    for (int c = 1; c <= budget && !finished; c++) begin
      next_cyc();
      start = (c == poke_c);
      if (c == poke_c) begin
        start_addr = '0;
        word_count = '0;
      end
      case (mode)
        0:       st_ready = 1'b1;
        1:       st_ready = c[0];
        default: st_ready = 1'($urandom_range(0, 1));
      endcase
      if (rej) begin
        chk("rej_cs", 32'(avm_chipselect), 32'd0);
        chk("rej_busy", 32'(busy), 32'd0);
        chk("rej_error", 32'(error), 32'(c == 1));
        if (c == 3) finished = 1'b1;
      end else begin
        if (c == 1) begin
          chk("busy_c1", 32'(busy), 32'd1);
          chk("cs_c1", 32'(avm_chipselect), 32'd1);
        end
        if (error) saw_err = 1'b1;
        if (avm_chipselect) begin
          issued++;
          chk("rd_addr", 32'(avm_address), 32'(sa + issued - 1));
          chk("fifo_room", 32'((issued - popped) <= FIFO_DEPTH), 32'd1);
          chk("over_issue", 32'(issued <= wc), 32'd1);
        end
        if (hold_v) begin
          chk("hold_valid", 32'(st_valid), 32'd1);
          chk("hold_data", st_data, hold_d);
          chk("hold_sop", 32'(st_sop), 32'(hold_s));
          chk("hold_eop", 32'(st_eop), 32'(hold_e));
        end
        hold_v = 1'b0;
        if (st_valid && st_ready) begin
          if (popped < wc) begin
            chk("st_data", st_data, rom[sa + popped]);
            chk("st_sop", 32'(st_sop), 32'(popped == 0));
            chk("st_eop", 32'(st_eop), 32'(popped == wc - 1));
            if (exact) chk("beat_cycle", 32'(c), 32'(popped + 3));
          end else begin
            chk("extra_beat", 32'(popped), 32'(wc - 1));
          end
          popped++;
        end else if (st_valid) begin
          hold_v = 1'b1;
          hold_d = st_data;
          hold_s = st_sop;
          hold_e = st_eop;
        end
        if (done) begin
          chk("done_count", 32'(popped), 32'(wc));
          chk("done_busy", 32'(busy), 32'd1);
          chk("no_error", 32'(saw_err), 32'd0);
          if (exact) chk("done_cycle", 32'(c), 32'(wc + 3));
          finished = 1'b1;
        end
      end
    end
    start = 1'b0;
    if (!finished) chk("timeout", 32'd0, 32'd1);
    if (!rej) begin
      next_cyc();
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_done", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int sa;
    int wc;
    int maxw;
    int mode;
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    st_ready   = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) rom[i] = 32'hA500_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    reset = 1'b0;
    next_cyc();

    run_xfer(16, 8, 0, 1'b1, -1);
    run_xfer(16, 8, 1, 1'b0, -1);
    run_xfer(10236, 4, 0, 1'b1, -1);
    run_xfer(10237, 4, 0, 1'b0, -1);
    run_xfer(5, 0, 0, 1'b0, -1);
    run_xfer(77, 1, 0, 1'b1, -1);
    run_xfer(100, 12, 0, 1'b1, 4);

    // Reset while the sink stalls partway through a packet.
    start      = 1'b1;
    start_addr = ADDR_W'(200);
    word_count = (ADDR_W+1)'(16);
    st_ready   = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      next_cyc();
      start    = 1'b0;
      st_ready = (c <= 5);
    end
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    next_cyc();
    check_idle_outputs("afterrst");
    run_xfer(200, 16, 0, 1'b1, -1);

    for (int i = 0; i < MEM_WORDS; i++) rom[i] = $urandom();
    for (int t = 0; t < 24; t++) begin
      sa   = int'($urandom_range(0, MEM_WORDS - 1));
      maxw = MEM_WORDS - sa;
      if (maxw > 40) maxw = 40;
      wc   = int'($urandom_range(1, maxw));
      if ($urandom_range(0, 5) == 0) wc = MEM_WORDS - sa + int'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) sa = MEM_WORDS - wc;
      mode = int'($urandom_range(0, 2));
      if (sa < 0) sa = 0;
      run_xfer(sa, wc, mode, mode == 0, -1);
      repeat ($urandom_range(0, 2)) next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
